// File: rtl/riego_pkg.sv
// Shared types and constants for the irrigation demand generator.
package riego_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WATER = 2'd2,
    HOLD  = 2'd3
  } zone_state_t;

  localparam logic [1:0] E_OK   = 2'b01;
  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_Z0   = 2'b01;
  localparam logic [1:0] G_Z1   = 2'b10;
  localparam logic [1:0] G_BOTH = 2'b11;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/riego_zone_ctl.sv
// One zone's demand FSM: hysteresis request, min/max watering time, timeout
// fault and fixed holdoff after any error or timeout.
module riego_zone_ctl
  import riego_pkg::*;
#(
  parameter int unsigned MOIST_W     = 8,
  parameter int unsigned DRY_TH      = 80,
  parameter int unsigned WET_TH      = 120,
  parameter int unsigned MIN_ON      = 16,
  parameter int unsigned MAX_ON      = 200,
  parameter int unsigned REQ_TIMEOUT = 32,
  parameter int unsigned HOLDOFF     = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [MOIST_W-1:0] moist_i,
  input  logic               valve_i,
  input  logic               err_i,
  input  logic               clr_fault_i,
  output logic               busy_o,
  output logic               fault_o
);

  localparam int unsigned CNT_W = $clog2(max3(MAX_ON, REQ_TIMEOUT, HOLDOFF) + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  zone_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             fault_set;
  logic             is_dry, is_wet;

  assign is_dry = moist_i <  MOIST_W'(DRY_TH);
  assign is_wet = moist_i >= MOIST_W'(WET_TH);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next state in per-state priority order, then counter and sticky fault.
  always_comb begin
    state_d   = state_q;
    fault_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!err_i && is_dry) state_d = REQ;
      end
      REQ: begin
        if (err_i) begin
          state_d = HOLD;
        end else if (valve_i) begin
          state_d = WATER;
        end else if (cnt_q == CNT_W'(REQ_TIMEOUT - 1)) begin
          state_d   = HOLD;
          fault_set = 1'b1;
        end
      end
      WATER: begin
        if (err_i) begin
          state_d = HOLD;
        end else if (cnt_q == CNT_W'(MAX_ON - 1)) begin
          state_d   = HOLD;
          fault_set = 1'b1;
        end else if (!valve_i) begin
          state_d = REQ;
        end else if (cnt_q >= CNT_W'(MIN_ON - 1) && is_wet) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLDOFF - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != IDLE && cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (fault_set) begin
      fault_d = 1'b1;
    end else if (clr_fault_i) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  assign busy_o  = (state_q == REQ) || (state_q == WATER);
  assign fault_o = fault_q;

endmodule

// File: rtl/riego_demand_gen.sv
// Per-garden requester: two independent zone controllers feeding the G demand code.
module riego_demand_gen
  import riego_pkg::*;
#(
  parameter int unsigned MOIST_W     = 8,
  parameter int unsigned DRY_TH      = 80,
  parameter int unsigned WET_TH      = 120,
  parameter int unsigned MIN_ON      = 16,
  parameter int unsigned MAX_ON      = 200,
  parameter int unsigned REQ_TIMEOUT = 32,
  parameter int unsigned HOLDOFF     = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MOIST_W-1:0] moist0,
  input  logic [MOIST_W-1:0] moist1,
  input  logic [1:0]         R,
  input  logic [1:0]         E,
  input  logic               clr_fault,
  output logic [1:0]         G,
  output logic [1:0]         busy,
  output logic [1:0]         fault
);

  logic       err_c;
  logic [1:0] zone_busy;
  logic [1:0] zone_fault;

  assign err_c = (E != E_OK);

  riego_zone_ctl #(
    .MOIST_W(MOIST_W), .DRY_TH(DRY_TH), .WET_TH(WET_TH), .MIN_ON(MIN_ON),
    .MAX_ON(MAX_ON), .REQ_TIMEOUT(REQ_TIMEOUT), .HOLDOFF(HOLDOFF)
  ) u_zone0 (
    .clk_i(clk), .reset_i(reset), .moist_i(moist0), .valve_i(R[0]),
    .err_i(err_c), .clr_fault_i(clr_fault), .busy_o(zone_busy[0]), .fault_o(zone_fault[0])
  );

  riego_zone_ctl #(
    .MOIST_W(MOIST_W), .DRY_TH(DRY_TH), .WET_TH(WET_TH), .MIN_ON(MIN_ON),
    .MAX_ON(MAX_ON), .REQ_TIMEOUT(REQ_TIMEOUT), .HOLDOFF(HOLDOFF)
  ) u_zone1 (
    .clk_i(clk), .reset_i(reset), .moist_i(moist1), .valve_i(R[1]),
    .err_i(err_c), .clr_fault_i(clr_fault), .busy_o(zone_busy[1]), .fault_o(zone_fault[1])
  );

  assign G     = zone_busy;
  assign busy  = zone_busy;
  assign fault = zone_fault;

endmodule

// File: doc/riego_demand_gen.md
Name: riego_demand_gen

Overview:
- Requester side of the irrigation handshake. One instance per garden drives that garden's 2-bit G demand code into the irrigation FSM.
- Consumes that garden's 2-bit valve status R and the shared error code E coming back from the FSM.
- Per zone: raises demand from a moisture reading with hysteresis, enforces minimum and maximum watering times, and backs off on error or non-response.

Parameters:
- MOIST_W, 8, moisture reading width (unsigned).
- DRY_TH, 80, zone requests water when moisture < DRY_TH.
- WET_TH, 120, zone may stop when moisture >= WET_TH. Must satisfy WET_TH > DRY_TH.
- MIN_ON, 16, minimum cycles in WATER before a wet exit is allowed.
- MAX_ON, 200, WATER cycles before a forced stop and fault.
- REQ_TIMEOUT, 32, REQ cycles without valve response before fault.
- HOLDOFF, 64, cycles spent in HOLD before returning to IDLE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- moist0  in  MOIST_W  zone 0 moisture.
- moist1  in  MOIST_W  zone 1 moisture.
- R  in  2  valve status from the FSM: bit z = 1 means zone z is flowing.
- E  in  2  error code from the FSM: 2'b01 = no error; any other value = error.
- clr_fault  in  1  clears sticky faults.
- G  out  2  demand code: bit z = zone z demand. 00 none, 01 zone0, 10 zone1, 11 both.
- busy  out  2  bit z = zone z in REQ or WATER.
- fault  out  2  sticky: zone z timed out (REQ_TIMEOUT or MAX_ON).

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on clk.
- Reset values: G=00, busy=00, fault=00, both zone states IDLE, all counters 0.
- Reset asserted mid-operation returns everything to these values on that edge; G drops the same cycle.
- err = (E != 2'b01). err is evaluated every cycle.
- Each zone runs an independent FSM: IDLE, REQ, WATER, HOLD.
- Outputs are Moore: G[z] = (state==REQ || state==WATER); busy equals G.
- Outputs are decoded from registered state, so the response appears one cycle after the input condition.
- One counter per zone. It clears on every state change and increments while in REQ, WATER or HOLD, saturating at its maximum.
- Transitions, listed in priority order within each state:
  - IDLE:
    - err -> stay IDLE.
    - moist < DRY_TH -> REQ.
  - REQ:
    - err -> HOLD.
    - R[z]=1 -> WATER.
    - cnt == REQ_TIMEOUT-1 -> HOLD and set fault[z].
  - WATER:
    - err -> HOLD.
    - cnt == MAX_ON-1 -> HOLD and set fault[z].
    - R[z]=0 -> REQ (valve dropped by controller; counter restarts).
    - cnt >= MIN_ON-1 and moist >= WET_TH -> IDLE.
  - HOLD:
    - cnt == HOLDOFF-1 -> IDLE. err does not extend HOLD.
- Hysteresis: moisture in [DRY_TH, WET_TH) never starts a request and never ends a watering on its own.
- Comparisons are unsigned, full MOIST_W width.
- Counter width is $clog2(max(MAX_ON, REQ_TIMEOUT, HOLDOFF)+1).
- Fault register:
  - fault[z] is set by timeout and cleared by clr_fault.
  - Set and clear in the same cycle: set wins.
  - fault does not block new requests.
- Both zones may be in WATER at once (G=11). The zones do not arbitrate against each other; arbitration belongs to the FSM.

Decomposition:
- riego_pkg holds:
  - zone_state_t enum {IDLE, REQ, WATER, HOLD}.
  - constants E_OK=2'b01, G_NONE=2'b00, G_Z0=2'b01, G_Z1=2'b10, G_BOTH=2'b11.
- Sub-module riego_zone_ctl: one zone's FSM, counter and fault bit, with the same parameters. It is instantiated twice.
- The top level only computes err, packs G/busy/fault, and distributes clr_fault.

Test Plan:
- Reset with moist0=50 -> G=00 for the cycle after reset. Release with E=01 -> G=01 one cycle later.
- Zone0 REQ, R=01 after 3 cycles, moist0 raised to 130 at WATER cycle 5 -> G stays 01 until cnt=15 -> G=00 next cycle, fault=00.
- Zone0 REQ, R held 00 -> G drops to 00 after 32 REQ cycles, fault=01. G stays 00 for 64 cycles, then re-requests. clr_fault pulse -> fault=00.
- Both zones dry, R=11, moisture held at 100 -> G=11 for 200 cycles, then G=00 and fault=11. Pulse clr_fault on the set cycle -> fault=11.
- Both zones watering, E=00 for 1 cycle -> G=00 next cycle, busy=00, HOLD lasts 64 cycles regardless of E.
- Zone1 WATER, R[1] drops to 0 -> G stays 10 (back to REQ). R[1]=1 again -> WATER with counter restarted: MIN_ON is re-enforced and exit happens no earlier than 16 cycles later.
